// File: rtl/rv32i_id_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, the NOP word,
// the decode FSM states and the immediate extraction helpers.
package rv32i_id_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } id_state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] iw);
        return {{20{iw[31]}}, iw[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] iw);
        return {{20{iw[31]}}, iw[31:25], iw[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] iw);
        return {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] iw);
        return {iw[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] iw);
        return {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Operand bypass selector: picks the youngest matching writeback source for one
// source register, falling back to the register file; x0 never forwards.
module rv32i_fwd_mux
    import rv32i_id_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = 32
)(
    input  logic [4:0]              i_rs,
    input  logic [XLEN-1:0]         i_rf_data,
    input  logic [NUM_FWD-1:0]      i_fwd_en,
    input  logic [5*NUM_FWD-1:0]    i_fwd_reg,
    input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
    input  logic [NUM_FWD-1:0]      i_fwd_is_load,
    output logic [XLEN-1:0]         o_data,
    output logic                    o_hit,
    output logic                    o_load_hit
);

    // Walk from oldest to youngest so the lowest matching index wins.
    always_comb begin
        o_data     = i_rf_data;
        o_hit      = 1'b0;
        o_load_hit = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_en[i] && (i_fwd_reg[i*5 +: 5] == i_rs) && (i_rs != 5'd0)) begin
                o_data     = i_fwd_data[i*XLEN +: XLEN];
                o_hit      = 1'b1;
                o_load_hit = i_fwd_is_load[i];
            end
        end
    end

endmodule

// File: rtl/rv32i_id_stage_hz.sv
// RV32I decode stage: operand bypassing, load-use stall, branch/jump resolution
// in decode with wrong-path squash, and a halt state entered on EBREAK/ECALL.
module rv32i_id_stage_hz
    import rv32i_id_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_FWD      = 3,
    parameter int FLUSH_CYCLES = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [31:0]             iw_in,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [XLEN-1:0]         rs1_data_in,
    input  logic [XLEN-1:0]         rs2_data_in,
    input  logic [NUM_FWD-1:0]      fwd_en,
    input  logic [5*NUM_FWD-1:0]    fwd_reg,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]      fwd_is_load,
    output logic [4:0]              rs1_reg,
    output logic [4:0]              rs2_reg,
    output logic                    stall_out,
    output logic                    jump_en_out,
    output logic [XLEN-1:0]         jump_addr,
    output logic                    valid_out,
    output logic [31:0]             iw_out,
    output logic [XLEN-1:0]         pc_out,
    output logic [XLEN-1:0]         rs1_data_out,
    output logic [XLEN-1:0]         rs2_data_out,
    output logic [4:0]              wb_reg_out,
    output logic                    wb_en_out,
    output logic                    mem_we_out,
    output logic                    halted
);

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES);

    id_state_t       r_state;
    id_state_t       w_state_nxt;
    logic [1:0]      r_flush_cnt;
    logic [1:0]      w_cnt_nxt;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_rs1_load;
    logic            w_rs2_load;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_load_use;
    logic            w_is_system;
    logic            w_br_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic            w_wb_en;
    logic            w_mem_we;
    logic            w_stall;
    logic            w_jump;
    logic            w_issue;

    assign w_opcode = iw_in[6:0];
    assign w_funct3 = iw_in[14:12];
    assign w_rd     = iw_in[11:7];
    assign rs1_reg  = iw_in[19:15];
    assign rs2_reg  = iw_in[24:20];

    rv32i_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs1 (
        .i_rs          (rs1_reg),
        .i_rf_data     (rs1_data_in),
        .i_fwd_en      (fwd_en),
        .i_fwd_reg     (fwd_reg),
        .i_fwd_data    (fwd_data),
        .i_fwd_is_load (fwd_is_load),
        .o_data        (w_rs1_val),
        .o_hit         (w_rs1_hit),
        .o_load_hit    (w_rs1_load)
    );

    rv32i_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs2 (
        .i_rs          (rs2_reg),
        .i_rf_data     (rs2_data_in),
        .i_fwd_en      (fwd_en),
        .i_fwd_reg     (fwd_reg),
        .i_fwd_data    (fwd_data),
        .i_fwd_is_load (fwd_is_load),
        .o_data        (w_rs2_val),
        .o_hit         (w_rs2_hit),
        .o_load_hit    (w_rs2_load)
    );

    assign w_uses_rs1  = !(w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign w_uses_rs2  = w_opcode inside {OP_BRANCH, OP_STORE, OP_OP};
    assign w_load_use  = valid_in && ((w_uses_rs1 && w_rs1_hit && w_rs1_load) ||
                                      (w_uses_rs2 && w_rs2_hit && w_rs2_load));
    assign w_is_system = (w_opcode == OP_SYSTEM);
    assign w_wb_en     = (w_rd != 5'd0) &&
                         (w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
    assign w_mem_we    = (w_opcode == OP_STORE);

    always_comb begin
        w_br_cond = 1'b0;
        unique case (w_funct3)
            3'b000:  w_br_cond = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_cond = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_cond = (w_rs1_val <  w_rs2_val);
            3'b111:  w_br_cond = (w_rs1_val >= w_rs2_val);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_rs1_val + imm_i(iw_in);

    always_comb begin
        w_taken  = 1'b0;
        w_target = '0;
        unique case (w_opcode)
            OP_JAL: begin
                w_taken  = 1'b1;
                w_target = pc_in + imm_j(iw_in);
            end
            OP_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: begin
                w_taken  = w_br_cond;
                w_target = pc_in + imm_b(iw_in);
            end
            default: ;
        endcase
    end

    // Stall outranks redirect; a halting instruction never issues into EX.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_flush_cnt;
        w_stall     = 1'b0;
        w_jump      = 1'b0;
        w_issue     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_load_use) begin
                    w_stall = 1'b1;
                end else if (valid_in && w_is_system) begin
                    w_state_nxt = HALT;
                end else if (valid_in) begin
                    w_issue = 1'b1;
                    if (w_taken) begin
                        w_jump      = 1'b1;
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            FLUSH: begin
                w_cnt_nxt = r_flush_cnt - 2'd1;
                if (r_flush_cnt <= 2'd1) begin
                    w_state_nxt = RUN;
                end
            end
            HALT: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign stall_out   = w_stall;
    assign jump_en_out = w_jump;
    assign jump_addr   = w_jump ? w_target : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_flush_cnt  <= '0;
            halted       <= 1'b0;
            valid_out    <= 1'b0;
            iw_out       <= NOP;
            pc_out       <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            wb_reg_out   <= '0;
            wb_en_out    <= 1'b0;
            mem_we_out   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_cnt_nxt;
            halted      <= (w_state_nxt == HALT);
            valid_out   <= w_issue;
            if (w_issue) begin
                iw_out       <= iw_in;
                pc_out       <= pc_in;
                rs1_data_out <= w_rs1_val;
                rs2_data_out <= w_rs2_val;
                wb_reg_out   <= w_rd;
                wb_en_out    <= w_wb_en;
                mem_we_out   <= w_mem_we;
            end else begin
                iw_out       <= NOP;
                pc_out       <= '0;
                rs1_data_out <= '0;
                rs2_data_out <= '0;
                wb_reg_out   <= '0;
                wb_en_out    <= 1'b0;
                mem_we_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_id_stage_hz.sv
// Scoreboard bench for rv32i_id_stage_hz: a behavioural decode model queues the
// expected EX slot per cycle and an independent monitor compares after each edge.
module tb_rv32i_id_stage_hz;

    localparam int NF = 3;
    localparam int FC = 2;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, IMM = 7'b0010011, OPR = 7'b0110011;

    logic            clk;
    logic            reset;
    logic            valid_in;
    logic [31:0]     iw_in;
    logic [31:0]     pc_in;
    logic [31:0]     rs1_data_in;
    logic [31:0]     rs2_data_in;
    logic [NF-1:0]   fwd_en;
    logic [5*NF-1:0] fwd_reg;
    logic [32*NF-1:0] fwd_data;
    logic [NF-1:0]   fwd_is_load;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic            stall_out;
    logic            jump_en_out;
    logic [31:0]     jump_addr;
    logic            valid_out;
    logic [31:0]     iw_out;
    logic [31:0]     pc_out;
    logic [31:0]     rs1_data_out;
    logic [31:0]     rs2_data_out;
    logic [4:0]      wb_reg_out;
    logic            wb_en_out;
    logic            mem_we_out;
    logic            halted;

    typedef struct {
        logic        isReset;
        logic        valid;
        logic [31:0] iw;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wb;
        logic        we;
        logic        halted;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: mode 0 = running, 1 = squashing wrong-path slots, 2 = halted.
    int   mMode = 0;
    int   mLeft = 0;

    logic [6:0] opList[9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OPR};

    rv32i_id_stage_hz #(.XLEN(32), .NUM_FWD(NF), .FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .iw_in        (iw_in),
        .pc_in        (pc_in),
        .rs1_data_in  (rs1_data_in),
        .rs2_data_in  (rs2_data_in),
        .fwd_en       (fwd_en),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
        .fwd_is_load  (fwd_is_load),
        .rs1_reg      (rs1_reg),
        .rs2_reg      (rs2_reg),
        .stall_out    (stall_out),
        .jump_en_out  (jump_en_out),
        .jump_addr    (jump_addr),
        .valid_out    (valid_out),
        .iw_out       (iw_out),
        .pc_out       (pc_out),
        .rs1_data_out (rs1_data_out),
        .rs2_data_out (rs2_data_out),
        .wb_reg_out   (wb_reg_out),
        .wb_en_out    (wb_en_out),
        .mem_we_out   (mem_we_out),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        logic [11:0] v;
        v = 12'(imm);
        return {v, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encB(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], BR};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearFwd();
        fwd_en      = '0;
        fwd_reg     = '0;
        fwd_data    = '0;
        fwd_is_load = '0;
    endtask

    // Evaluate the current inputs against the behavioural model, check the
    // same-cycle outputs, queue the expected EX slot, then advance one clock.
    task automatic applyStimulus();
        exp_t        e;
        logic [31:0] a1, a2, addr;
        logic [4:0]  r1, r2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          l1, l2, f1, f2, use1, use2, loadUse, taken, expStall, expJump;
        logic signed [20:0] jv;
        logic signed [12:0] bv;
        logic signed [11:0] iv;
        int          ji, bi, ii;

        #1;
        r1 = iw_in[19:15];
        r2 = iw_in[24:20];
        opc = iw_in[6:0];
        f3 = iw_in[14:12];
        a1 = rs1_data_in;
        a2 = rs2_data_in;
        l1 = 0; l2 = 0; f1 = 0; f2 = 0;
        for (int i = 0; i < NF; i++) begin
            if (!f1 && fwd_en[i] && fwd_reg[i*5 +: 5] == r1 && r1 != 0) begin
                f1 = 1; a1 = fwd_data[i*32 +: 32]; l1 = fwd_is_load[i];
            end
            if (!f2 && fwd_en[i] && fwd_reg[i*5 +: 5] == r2 && r2 != 0) begin
                f2 = 1; a2 = fwd_data[i*32 +: 32]; l2 = fwd_is_load[i];
            end
        end
        use1 = !(opc == LUI || opc == AUIPC || opc == JAL);
        use2 = (opc == BR || opc == ST || opc == OPR);
        loadUse = valid_in && ((use1 && l1) || (use2 && l2));

        jv = {iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};
        bv = {iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
        iv = iw_in[31:20];
        ji = jv; bi = bv; ii = iv;
        taken = 0;
        addr = 0;
        if (opc == JAL) begin
            taken = 1; addr = pc_in + ji;
        end else if (opc == JALR) begin
            taken = 1; addr = (a1 + ii) & 32'hFFFF_FFFE;
        end else if (opc == BR) begin
            addr = pc_in + bi;
            case (f3)
                3'd0: taken = (a1 == a2);
                3'd1: taken = (a1 != a2);
                3'd4: taken = ($signed(a1) <  $signed(a2));
                3'd5: taken = ($signed(a1) >= $signed(a2));
                3'd6: taken = (a1 <  a2);
                3'd7: taken = (a1 >= a2);
                default: taken = 0;
            endcase
        end

        e = '{isReset: 0, valid: 0, iw: 32'h13, pc: 0, op1: 0, op2: 0,
              rd: 0, wb: 0, we: 0, halted: 0};
        expStall = 0;
        expJump = 0;

        if (reset) begin
            e.isReset = 1;
            mMode = 0;
            mLeft = 0;
        end else begin
            if (mMode == 2) begin
                expStall = 1;
            end else if (mMode == 1) begin
                mLeft--;
                if (mLeft == 0) mMode = 0;
            end else if (loadUse) begin
                expStall = 1;
            end else if (valid_in && opc == 7'b1110011) begin
                mMode = 2;
            end else if (valid_in) begin
                e.valid = 1;
                e.iw = iw_in;
                e.pc = pc_in;
                e.op1 = a1;
                e.op2 = a2;
                e.rd = iw_in[11:7];
                e.wb = (iw_in[11:7] != 0) &&
                       (opc == LUI || opc == AUIPC || opc == JAL || opc == JALR ||
                        opc == LD || opc == IMM || opc == OPR);
                e.we = (opc == ST);
                if (taken) begin
                    expJump = 1;
                    mMode = 1;
                    mLeft = FC;
                end
            end
            e.halted = (mMode == 2);
            checkOutput("rs1_reg", 32'(rs1_reg), 32'(r1));
            checkOutput("rs2_reg", 32'(rs2_reg), 32'(r2));
            checkOutput("stall_out", 32'(stall_out), 32'(expStall));
            checkOutput("jump_en_out", 32'(jump_en_out), 32'(expJump));
            checkOutput("jump_addr", jump_addr, expJump ? addr : 32'h0);
        end
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new EX slot after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("valid_out", 32'(valid_out), 32'(e.valid));
                checkOutput("iw_out", iw_out, e.iw);
                checkOutput("wb_en_out", 32'(wb_en_out), 32'(e.wb));
                checkOutput("mem_we_out", 32'(mem_we_out), 32'(e.we));
                checkOutput("halted", 32'(halted), 32'(e.halted));
                if (e.isReset || e.valid) begin
                    checkOutput("pc_out", pc_out, e.pc);
                    checkOutput("rs1_data_out", rs1_data_out, e.op1);
                    checkOutput("rs2_data_out", rs2_data_out, e.op2);
                    checkOutput("wb_reg_out", 32'(wb_reg_out), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        reset = 1; valid_in = 0; iw_in = 32'h13; pc_in = 0;
        rs1_data_in = 0; rs2_data_in = 0;
        clearFwd();
        repeat (2) applyStimulus();
        reset = 0;

        // All three sources match x5; the youngest must win.
        valid_in = 1; pc_in = 32'h40; iw_in = encR(5, 5, 0, 1);
        rs1_data_in = 32'h11; rs2_data_in = 32'h22;
        fwd_en = 3'b111; fwd_reg = {5'd5, 5'd5, 5'd5};
        fwd_data = {32'hC, 32'hB, 32'hA};
        applyStimulus();

        // Load-use on rs1, then the load data arrives.
        clearFwd();
        iw_in = encI(1, 3, 0, 4, IMM); pc_in = 32'h44;
        fwd_en = 3'b001; fwd_reg[4:0] = 5'd3; fwd_is_load = 3'b001; fwd_data[31:0] = 32'h55;
        applyStimulus();
        fwd_is_load = 3'b000;
        applyStimulus();

        // Taken BEQ, then two wrong-path slots squashed.
        clearFwd();
        pc_in = 32'h100; iw_in = encB(16, 2, 1, 0);
        rs1_data_in = 7; rs2_data_in = 7;
        applyStimulus();
        iw_in = encI(3, 1, 0, 2, IMM); pc_in = 32'h104;
        repeat (2) applyStimulus();

        // JALR clears bit 0 of the target; rd=x0 suppresses writeback.
        iw_in = encI(5, 2, 0, 1, JALR); pc_in = 32'h200; rs1_data_in = 32'h203;
        applyStimulus();
        repeat (2) applyStimulus();
        iw_in = encI(5, 2, 0, 0, JALR);
        applyStimulus();
        repeat (2) applyStimulus();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opList[$urandom_range(0, 8)];
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            w[11:7] = 5'($urandom_range(0, 7));
            iw_in = w;
            valid_in = ($urandom_range(0, 4) != 0);
            pc_in = $urandom;
            rs1_data_in = ($urandom_range(0, 3) == 0) ? rs2_data_in : $urandom;
            rs2_data_in = $urandom;
            for (int i = 0; i < NF; i++) begin
                fwd_en[i] = $urandom_range(0, 1);
                fwd_reg[i*5 +: 5] = 5'($urandom_range(0, 7));
                fwd_data[i*32 +: 32] = $urandom;
                fwd_is_load[i] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end

        // Reset in the middle of a flush window.
        clearFwd();
        valid_in = 1; pc_in = 32'h300; iw_in = encB(-8, 2, 1, 1);
        rs1_data_in = 1; rs2_data_in = 2;
        applyStimulus();
        iw_in = encI(9, 1, 0, 3, IMM);
        applyStimulus();
        reset = 1;
        applyStimulus();
        reset = 0;
        applyStimulus();

        // EBREAK halts until reset.
        iw_in = 32'h00100073;
        applyStimulus();
        iw_in = encI(1, 1, 0, 1, IMM);
        repeat (20) applyStimulus();
        reset = 1;
        applyStimulus();
        reset = 0;
        applyStimulus();

        valid_in = 0;
        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
